dmem_access_ctrl: RTL

Sequences every data-memory access from the MEM stage.
- Accepts one load or store request at a time and detects misalignment before any bus activity.
- Issues the bus transaction with a valid/ready handshake, waits for the response and guards it with a timeout.
- Returns formatted load data, or a misaligned/fault status, to the pipeline as a single-cycle response.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/load_unit.sv | 42 ++++
 rtl/store_unit.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
//   state_t        : access FSM states
//   LS_* / SS_*    : bit positions inside the load/store size one-hot vectors
//   DEFAULT_TIMEOUT: default number of WAIT cycles before an access fault
//   lowest_load / lowest_store : keep only the lowest set bit of a size vector
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int LS_B  = 0;
  localparam int LS_BU = 1;
  localparam int LS_H  = 2;
  localparam int LS_HU = 3;
  localparam int LS_W  = 4;

  localparam int SS_B = 0;
  localparam int SS_H = 1;
  localparam int SS_W = 2;

  localparam int DEFAULT_TIMEOUT = 255;

  // Two's-complement trick: v & -v isolates the lowest set bit.
  function automatic logic [4:0] lowest_load(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

  function automatic logic [2:0] lowest_store(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/load_unit.sv
// Load lane logic: read strobes, load data formatting and load misalignment.
//   addr_lo     : byte offset within the word
//   size_onehot : {w, hu, h, bu, b}; lowest set bit wins
//   raw_rdata   : word as returned by the bus
//   rstrb       : byte read strobes
//   rdata       : shifted and sign/zero-extended load data
//   misaligned  : access violates natural alignment
module load_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  size_onehot,
  input  logic [31:0] raw_rdata,
  output logic [3:0]  rstrb,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [4:0]  sz;
  logic [31:0] lane;

  always_comb begin
    sz         = lowest_load(size_onehot);
    lane       = raw_rdata >> {addr_lo, 3'b000};
    rstrb      = 4'b0000;
    rdata      = 32'h0;
    misaligned = 1'b0;
    if (sz[LS_B] || sz[LS_BU]) begin
      rstrb = 4'b0001 << addr_lo;
      rdata = {{24{sz[LS_B] & lane[7]}}, lane[7:0]};
    end else if (sz[LS_H] || sz[LS_HU]) begin
      rstrb      = 4'b0011 << {addr_lo[1], 1'b0};
      rdata      = {{16{sz[LS_H] & lane[15]}}, lane[15:0]};
      misaligned = addr_lo[0];
    end else if (sz[LS_W]) begin
      rstrb      = 4'hf;
      rdata      = raw_rdata;
      misaligned = |addr_lo;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store lane logic: write strobes, lane-shifted store data and store misalignment.
//   addr_lo     : byte offset within the word
//   size_onehot : {w, h, b}; lowest set bit wins
//   wdata       : right-aligned store data
//   wstrb       : byte write strobes
//   wdata_sh    : store data moved onto its byte lanes
//   misaligned  : access violates natural alignment
module store_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size_onehot,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic        misaligned
);

  logic [2:0] sz;

  always_comb begin
    sz         = lowest_store(size_onehot);
    wdata_sh   = wdata << {addr_lo, 3'b000};
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    if (sz[SS_B]) begin
      wstrb = 4'b0001 << addr_lo;
    end else if (sz[SS_H]) begin
      wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
      misaligned = addr_lo[0];
    end else if (sz[SS_W]) begin
      wstrb      = 4'hf;
      misaligned = |addr_lo;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Accepts one load/store at a time, rejects misaligned or zero-size accesses
// without bus activity, runs a valid/ready bus request, waits (with timeout)
// for the response and returns a one-cycle formatted response.
//   req_*       : pipeline request side (req_ready high only in IDLE)
//   flush       : kill the current access
//   mem_*       : bus request/response side
//   resp_*      : completion pulse and its held result fields
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  load_size_onehot,
  input  logic [2:0]  store_size_onehot,
  input  logic        flush,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [3:0]  mem_rstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] timer;
  logic        killed;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [4:0]  lsize_q;
  logic [2:0]  ssize_q;

  logic        in_idle;
  logic        in_issue;
  logic [1:0]  cur_addr_lo;
  logic [4:0]  cur_lsize;
  logic [2:0]  cur_ssize;
  logic [3:0]  ld_rstrb;
  logic [31:0] ld_rdata;
  logic        ld_mis;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        st_mis;
  logic        req_mis;
  logic        req_zero;
  logic        kill_now;

  // In IDLE the lane units look at the incoming request so misalignment is
  // known at acceptance; afterwards they run off the latched access.
  assign in_idle     = (state == IDLE);
  assign in_issue    = (state == ISSUE);
  assign cur_addr_lo = in_idle ? req_addr[1:0]     : addr_q[1:0];
  assign cur_lsize   = in_idle ? load_size_onehot  : lsize_q;
  assign cur_ssize   = in_idle ? store_size_onehot : ssize_q;

  load_unit u_load (
    .addr_lo     (cur_addr_lo),
    .size_onehot (cur_lsize),
    .raw_rdata   (mem_rdata),
    .rstrb       (ld_rstrb),
    .rdata       (ld_rdata),
    .misaligned  (ld_mis)
  );

  store_unit u_store (
    .addr_lo     (cur_addr_lo),
    .size_onehot (cur_ssize),
    .wdata       (wdata_q),
    .wstrb       (st_wstrb),
    .wdata_sh    (st_wdata),
    .misaligned  (st_mis)
  );

  assign req_mis  = req_we ? st_mis : ld_mis;
  assign req_zero = req_we ? (store_size_onehot == 3'b000) : (load_size_onehot == 5'b00000);
  assign kill_now = killed | flush;

  // Bus fields are driven only while the request is outstanding; the latched
  // access keeps them stable until mem_ready.
  assign req_ready  = in_idle;
  assign mem_valid  = in_issue;
  assign mem_addr   = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we     = in_issue & we_q;
  assign mem_wdata  = (in_issue & we_q) ? st_wdata : 32'h0;
  assign mem_wstrb  = (in_issue & we_q) ? st_wstrb : 4'b0000;
  assign mem_rstrb  = (in_issue & ~we_q) ? ld_rstrb : 4'b0000;
  assign resp_valid = (state == RESP) & ~kill_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= 16'h0;
      killed          <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (req_valid && !flush) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            lsize_q <= load_size_onehot;
            ssize_q <= store_size_onehot;
            if (req_mis || req_zero) begin
              resp_rdata      <= 32'h0;
              resp_misaligned <= req_mis;
              resp_fault      <= 1'b0;
              state           <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush) killed <= 1'b1;
          if (mem_ready) begin
            timer <= 16'h0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) killed <= 1'b1;
          // A response on the final timer cycle wins over the timeout.
          if (mem_rvalid) begin
            state <= kill_now ? IDLE : RESP;
            if (!kill_now) begin
              resp_rdata      <= (we_q || mem_err) ? 32'h0 : ld_rdata;
              resp_misaligned <= 1'b0;
              resp_fault      <= mem_err;
            end
          end else if (timer == TIMER_LAST) begin
            state <= kill_now ? IDLE : RESP;
            if (!kill_now) begin
              resp_rdata      <= 32'h0;
              resp_misaligned <= 1'b0;
              resp_fault      <= 1'b1;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
